lifo_stack: RTL and testbench
=============================

LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 SHALL have parameter SIZEDATA, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTHSTACK, default 8, number of stored words (power of two, >= 2).
REQ-003 SHALL have parameter BITSCONT, default $clog2(DEPTHSTACK), pointer width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port valid_i  input  1  push request; data_i carries a word.
REQ-007 SHALL have port data_i  input  SIZEDATA  word to push.
REQ-008 SHALL have port ready_o  output  1  stack can accept a push.
REQ-009 SHALL have port valid_o  output  1  top-of-stack word is available on data_o.
REQ-010 SHALL have port data_o  output  SIZEDATA  current top-of-stack word.
REQ-011 SHALL have port ready_i  input  1  consumer accepts data_o (pop request).
REQ-012 SHALL have port flush_i  input  1  synchronous discard of all stored words.
REQ-013 SHALL have port count_o  output  BITSCONT+1  number of stored words, 0..DEPTHSTACK.

Function
REQ-014 SHALL store words in a DEPTHSTACK-entry array addressed by an internal count register; top entry = array[count-1].
REQ-015 SHALL drive ready_o = 1 iff count < DEPTHSTACK; valid_o = 1 iff count > 0 (both combinational from count).
REQ-016 SHALL drive data_o = array[count-1] combinationally when count > 0, and all-zeros when count = 0.
REQ-017 SHALL accept a push on a rising edge with valid_i & ready_o; pop on a rising edge with valid_o & ready_i.
REQ-018 Push only: write data_i to array[count], count += 1; new word visible on data_o the cycle after the edge.
REQ-019 Pop only: count -= 1; consumer samples data_o before the edge; next-older word appears after the edge.
REQ-020 Push and pop same edge (0 < count < DEPTHSTACK): popped word = pre-edge data_o; data_i overwrites array[count-1]; count unchanged.
REQ-021 Full (count = DEPTHSTACK): ready_o = 0; valid_i ignored; a pop in this state SHALL proceed and count -> DEPTHSTACK-1.
REQ-022 Empty (count = 0): valid_o = 0; ready_i ignored; a push proceeds, count -> 1.
REQ-023 Words SHALL pop in strict reverse order of acceptance (last-in first-out).
REQ-024 flush_i = 1 on an edge SHALL set count to 0, overriding any push or pop on that edge; array contents are not cleared.
REQ-025 count SHALL never wrap: no increment past DEPTHSTACK, no decrement below 0, under any input combination.
REQ-026 count_o SHALL equal the internal count register (registered, no combinational path from inputs).
REQ-027 Array contents SHALL change only on an accepted push; dropped pushes (ready_o = 0 or flush_i) leave the array unchanged.

Reset
REQ-028 rstn_i = 0 SHALL immediately (asynchronously) set count to 0: ready_o = 1, valid_o = 0, data_o = 0, count_o = 0.
REQ-029 Array storage SHALL NOT be reset; no stale word is observable because data_o is forced to 0 while count = 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; first edge after rstn_i rises behaves as from empty.
REQ-031 While rstn_i = 0, pushes, pops and flush_i SHALL have no effect.

Verification
REQ-032 Reset, push 5 (one edge), then pop one edge -> count_o 1 then 0; data_o = 5 before the pop edge; valid_o 0 after.
REQ-033 Push 12 random words with valid_i held -> first 8 accepted, ready_o = 0 from count 8; then drain -> words 8..1 in reverse order, valid_o drops after 8 pops.
REQ-034 Stack holding A,B (B on top), push C with simultaneous pop -> B consumed, data_o = C next cycle, count_o stays 2; then pop -> C, then A.
REQ-035 Full stack, valid_i = 1 and ready_i = 1 same edge -> only pop: top word consumed, count_o = 7, array[7] not overwritten.
REQ-036 Count 3, flush_i = 1 with valid_i = 1 same edge -> count_o = 0, valid_o = 0, data_o = 0; next push of 0xDEAD -> data_o = 0xDEAD, count_o 1.
REQ-037 Push 4 words, drop rstn_i between clock edges -> count_o, valid_o, data_o go to 0 without a clock edge; release, push 7 -> data_o = 7.

Source files
------------

// File: rtl/lifo_stack.sv
// Last-in first-out word stack with valid/ready push and pop handshakes.
// The storage array is not reset; data_o is forced to zero whenever the stack is empty.
module lifo_stack #(
    parameter int SIZEDATA   = 32,
    parameter int DEPTHSTACK = 8,
    parameter int BITSCONT   = $clog2(DEPTHSTACK)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                valid_i,
    input  logic [SIZEDATA-1:0] data_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [SIZEDATA-1:0] data_o,
    input  logic                ready_i,
    input  logic                flush_i,
    output logic [BITSCONT:0]   count_o
);

    localparam logic [BITSCONT:0] ONE_CNT  = (BITSCONT+1)'(1);
    localparam logic [BITSCONT:0] FULL_CNT = (BITSCONT+1)'(DEPTHSTACK);

    logic [SIZEDATA-1:0] mem [DEPTHSTACK];
    logic [BITSCONT:0]   count;
    logic [BITSCONT:0]   top_idx;
    logic [BITSCONT:0]   wr_idx;
    logic                push;
    logic                pop;
    logic                wr_en;

    assign ready_o = (count < FULL_CNT);
    assign valid_o = (count != '0);
    assign count_o = count;

    assign push  = valid_i & ready_o;
    assign pop   = valid_o & ready_i;
    assign wr_en = push & ~flush_i;

    assign top_idx = count - ONE_CNT;
    // A simultaneous push and pop replaces the current top in place.
    assign wr_idx  = pop ? top_idx : count;

    assign data_o = valid_o ? mem[top_idx[BITSCONT-1:0]] : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + ONE_CNT;
        end else if (pop && !push) begin
            count <= count - ONE_CNT;
        end
    end

    // Storage has no reset; writes are still blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (rstn_i && wr_en) begin
            mem[wr_idx[BITSCONT-1:0]] <= data_i;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_lifo_stack;

    localparam int W = 32;
    localparam int D = 8;
    localparam int B = $clog2(D);

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         ready_i;
    logic         flush_i;
    logic [B:0]   count_o;

    int n_tests = 0;
    int n_fail  = 0;

    lifo_stack #(.SIZEDATA(W), .DEPTHSTACK(D)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .flush_i (flush_i),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input int cnt, input logic [W-1:0] top);
        check({name, ".count"}, W'(count_o), W'(cnt));
        check({name, ".valid"}, W'(valid_o), W'(cnt > 0));
        check({name, ".ready"}, W'(ready_o), W'(cnt < D));
        check({name, ".data"},  data_o, (cnt > 0) ? top : '0);
    endtask

    // Drive inputs just after a falling edge, then sample 1 time unit after the next rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        @(negedge clk_i);
        valid_i = v; data_i = d; ready_i = r; flush_i = f;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         f;
        int           exp_cnt;
        logic [W-1:0] exp_top;
    } vec_t;

    vec_t vecs [12];
    logic [W-1:0] words [12];
    logic [W-1:0] mq [$];

    initial begin
        rstn_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; flush_i = 1'b0;
        #1;
        check_outs("reset", 0, '0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        vecs[0]  = '{1'b1, 32'h5,    1'b0, 1'b0, 1, 32'h5};
        vecs[1]  = '{1'b0, 32'h0,    1'b1, 1'b0, 0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,    1'b1, 1'b0, 0, 32'h0};
        vecs[3]  = '{1'b1, 32'h11,   1'b0, 1'b0, 1, 32'h11};
        vecs[4]  = '{1'b1, 32'h22,   1'b0, 1'b0, 2, 32'h22};
        vecs[5]  = '{1'b1, 32'h33,   1'b1, 1'b0, 2, 32'h33};
        vecs[6]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1, 32'h11};
        vecs[7]  = '{1'b1, 32'h44,   1'b0, 1'b0, 2, 32'h44};
        vecs[8]  = '{1'b1, 32'h55,   1'b0, 1'b0, 3, 32'h55};
        vecs[9]  = '{1'b1, 32'hAA,   1'b0, 1'b1, 0, 32'h0};
        vecs[10] = '{1'b1, 32'hDEAD, 1'b0, 1'b0, 1, 32'hDEAD};
        vecs[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_top);
        end

        // Hold valid_i for 12 words: only the first 8 are accepted.
        for (int i = 0; i < 12; i++) words[i] = $urandom;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; data_i = words[i]; ready_i = 1'b0; flush_i = 1'b0;
            #1;
            check($sformatf("fill%0d.ready", i), W'(ready_o), W'(i < D));
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        check_outs("fill.full", D, words[D-1]);
        for (int k = 0; k < D; k++) begin
            @(negedge clk_i);
            ready_i = 1'b1;
            #1;
            check($sformatf("drain%0d.data", k), data_o, words[D-1-k]);
        end
        @(negedge clk_i);
        ready_i = 1'b0;
        #1;
        check_outs("drain.empty", 0, '0);

        // Full stack with push and pop on the same edge: only the pop happens.
        for (int i = 0; i < D; i++) cycle(1'b1, words[i], 1'b0, 1'b0);
        cycle(1'b1, 32'hBAD0BAD0, 1'b1, 1'b0);
        check_outs("full_pushpop", D-1, words[D-2]);
        cycle(1'b1, 32'h1234, 1'b0, 1'b0);
        check_outs("full_refill", D, 32'h1234);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_outs("full_pop", D-1, words[D-2]);

        // Asynchronous reset between edges, then pushes ignored while held.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + i, 1'b0, 1'b0);
        check_outs("pre_rst", 4, 32'h103);
        @(negedge clk_i);
        valid_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        check_outs("async_rst", 0, '0);
        valid_i = 1'b1; data_i = 32'h99; ready_i = 1'b1; flush_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check_outs("rst_held", 0, '0);
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b0;
        rstn_i = 1'b1;
        cycle(1'b1, 32'h7, 1'b0, 1'b0);
        check_outs("post_rst", 1, 32'h7);

        // Randomized traffic against a queue model.
        mq.delete();
        mq.push_back(32'h7);
        for (int i = 0; i < 400; i++) begin
            logic v, r, f;
            logic [W-1:0] d;
            logic acc_push, acc_pop;
            @(negedge clk_i);
            v = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 3);
            d = $urandom;
            valid_i = v; ready_i = r; flush_i = f; data_i = d;
            #1;
            check_outs($sformatf("rnd%0d", i), mq.size(), (mq.size() > 0) ? mq[$] : '0);
            acc_push = v && (mq.size() < D);
            acc_pop  = r && (mq.size() > 0);
            if (f) mq.delete();
            else begin
                if (acc_pop) void'(mq.pop_back());
                if (acc_push) mq.push_back(d);
            end
        end
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        #1;
        check_outs("rnd.final", mq.size(), (mq.size() > 0) ? mq[$] : '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
